irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_pkg.sv | 23 ++
 rtl/irq_controller_if.sv | 30 +++
 rtl/irq_prio_enc.sv | 18 +
 rtl/irq_controller.sv | 99 +++++++++
 tb/tb_irq_controller.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
// Optional feature macro: IRQ_VECTOR_EN (adds the irq_vector output).
package irq_pkg;

  localparam int NUM_IRQ = 4;
  localparam int IDX_W   = $clog2(NUM_IRQ);

  localparam logic [7:0] IRQ_OPCODE   = 8'hEF;
  localparam logic [7:0] IRQ_VEC_BASE = 8'hF0;

  // FSM state; encodings kept as plain constants so older tools see fixed bits
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PENDING = 2'd1;
  localparam state_t ST_INJECT  = 2'd2;
  localparam state_t ST_SERVICE = 2'd3;

  // Handler vectors are two bytes apart, starting at IRQ_VEC_BASE
  function automatic logic [7:0] vec_of(input logic [IDX_W-1:0] w);
    return IRQ_VEC_BASE + 8'({w, 1'b0});
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Requester / control-word side of the interrupt controller.
// Optional feature macro: IRQ_VECTOR_EN (adds irq_vector).
interface irq_controller_if;
  import irq_pkg::*;

  logic [NUM_IRQ-1:0] irq_req;
  logic               mask_wr;
  logic [NUM_IRQ-1:0] mask_in;
  logic               ie_set;
  logic               ie_clr;
  logic               reti;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               irq_active;
`ifdef IRQ_VECTOR_EN
  logic [7:0]         irq_vector;
`endif

`ifdef IRQ_VECTOR_EN
  modport master (output irq_req, mask_wr, mask_in, ie_set, ie_clr, reti,
                  input  irq_ack, irq_active, irq_vector);
  modport slave  (input  irq_req, mask_wr, mask_in, ie_set, ie_clr, reti,
                  output irq_ack, irq_active, irq_vector);
`else
  modport master (output irq_req, mask_wr, mask_in, ie_set, ie_clr, reti,
                  input  irq_ack, irq_active);
  modport slave  (input  irq_req, mask_wr, mask_in, ie_set, ie_clr, reti,
                  output irq_ack, irq_active);
`endif

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // scan from the top so the lowest set index is written last
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (req[i]) idx = i[IDX_W-1:0];
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: masks and prioritises level requests, injects
// IRQ_OPCODE at an instruction boundary, tracks the handler until reti.
// Optional feature macro: IRQ_VECTOR_EN (registered handler vector).
module irq_controller
  import irq_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  irq_controller_if.slave   bus,
  input  logic              step_resetn,
  input  logic              step_extn,
  input  logic [7:0]        opcode_in,
  output logic [7:0]        opcode_out
);

  state_t             state;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] ack;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_vld;
  logic               ie;
  logic               go_inject;
  logic               go_return;

  assign pending = bus.irq_req & mask;

  irq_prio_enc u_enc (
    .req   (pending),
    .idx   (enc_idx),
    .valid (enc_vld)
  );

  // injection only at a boundary that does not sit inside a prefixed instruction
  assign go_inject = (state == ST_PENDING) && ie && enc_vld && !step_resetn && step_extn;
  assign go_return = (state == ST_SERVICE) && bus.reti;

  // FSM, mask, global enable and the one-cycle acknowledge pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      mask   <= '0;
      ie     <= 1'b0;
      winner <= '0;
      ack    <= '0;
    end else begin
      ack <= '0;
      if (bus.mask_wr) mask <= bus.mask_in;
      // clear beats set when both strobes arrive together
      if (bus.ie_clr)      ie <= 1'b0;
      else if (bus.ie_set) ie <= 1'b1;

      case (state)
        ST_IDLE:
          if (ie && enc_vld) begin
            state  <= ST_PENDING;
            winner <= enc_idx;
          end
        ST_PENDING:
          if (!ie || !enc_vld) begin
            state <= ST_IDLE;
          end else if (go_inject) begin
            state <= ST_INJECT;
            ack   <= NUM_IRQ'(1) << winner;
            ie    <= 1'b0;
          end
        ST_INJECT:
          if (!step_resetn) state <= ST_SERVICE;
        ST_SERVICE:
          if (go_return) begin
            state <= ST_IDLE;
            ie    <= 1'b1;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.irq_ack    = ack;
  assign bus.irq_active = (state == ST_SERVICE);

  // the injected opcode replaces the fetched one only while in INJECT
  assign opcode_out = (state == ST_INJECT) ? IRQ_OPCODE : opcode_in;

`ifdef IRQ_VECTOR_EN
  logic [7:0] vector;

  // vector captured with the acknowledge, dropped when the handler returns
  always_ff @(posedge clk) begin
    if (!rstn)          vector <= '0;
    else if (go_inject) vector <= vec_of(winner);
    else if (go_return) vector <= '0;
  end

  assign bus.irq_vector = vector;
`endif

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller; scenario tasks plus a randomized
// priority sweep checked against a lowest-set-bit reference.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       rstn;
  logic       step_resetn;
  logic       step_extn;
  logic [7:0] opcode_in;
  logic [7:0] opcode_out;

  int checks = 0;
  int errors = 0;

  irq_controller_if bus ();

  irq_controller dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .step_resetn (step_resetn),
    .step_extn   (step_extn),
    .opcode_in   (opcode_in),
    .opcode_out  (opcode_out)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- drive helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.irq_req = '0;
    bus.mask_wr = 1'b0;
    bus.mask_in = '0;
    bus.ie_set  = 1'b0;
    bus.ie_clr  = 1'b0;
    bus.reti    = 1'b0;
    step_resetn = 1'b1;
    step_extn   = 1'b1;
  endtask

  task automatic new_op();
    opcode_in = 8'($urandom_range(0, 8'hEE));
  endtask

  task automatic do_reset();
    idle_inputs();
    new_op();
    rstn = 1'b0;
    cyc();
    cyc();
    rstn = 1'b1;
  endtask

  task automatic set_mask(input logic [3:0] m);
    bus.mask_wr = 1'b1;
    bus.mask_in = m;
    cyc();
    bus.mask_wr = 1'b0;
  endtask

  task automatic set_ie();
    bus.ie_set = 1'b1;
    cyc();
    bus.ie_set = 1'b0;
  endtask

  task automatic to_pending(input logic [3:0] r, input logic [3:0] m);
    bus.irq_req = r;
    set_mask(m);
    set_ie();
    cyc();
  endtask

  task automatic boundary();
    step_resetn = 1'b0;
    cyc();
    step_resetn = 1'b1;
  endtask

  task automatic do_reti();
    bus.reti = 1'b1;
    cyc();
    bus.reti = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    new_op();
    rstn = 1'b0;
    cyc();
    #1;
    checks++; if (bus.irq_ack !== 4'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0000", bus.irq_ack); end
    checks++; if (bus.irq_active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", bus.irq_active); end
    checks++; if (opcode_out !== opcode_in) begin errors++; $display("FAIL reset_opcode got=%h exp=%h", opcode_out, opcode_in); end
`ifdef IRQ_VECTOR_EN
    checks++; if (bus.irq_vector !== 8'h00) begin errors++; $display("FAIL reset_vector got=%h exp=00", bus.irq_vector); end
`endif
    rstn = 1'b1;
    // mask and ie must both be 0 out of reset: a request and boundaries do nothing
    bus.irq_req = 4'hF;
    cyc();
    boundary();
    boundary();
    checks++; if (bus.irq_ack !== 4'b0) begin errors++; $display("FAIL reset_no_irq got=%b exp=0000", bus.irq_ack); end
  endtask

  task automatic test_basic();
    do_reset();
    to_pending(4'b0100, 4'hF);
    checks++; if (bus.irq_ack !== 4'b0) begin errors++; $display("FAIL basic_pending_ack got=%b exp=0000", bus.irq_ack); end
    checks++; if (opcode_out !== opcode_in) begin errors++; $display("FAIL basic_pending_op got=%h exp=%h", opcode_out, opcode_in); end
    boundary();
    checks++; if (bus.irq_ack !== 4'b0100) begin errors++; $display("FAIL basic_ack got=%b exp=0100", bus.irq_ack); end
    checks++; if (opcode_out !== 8'hEF) begin errors++; $display("FAIL basic_inject_op got=%h exp=ef", opcode_out); end
    checks++; if (bus.irq_active !== 1'b0) begin errors++; $display("FAIL basic_inject_active got=%b exp=0", bus.irq_active); end
`ifdef IRQ_VECTOR_EN
    checks++; if (bus.irq_vector !== 8'hF4) begin errors++; $display("FAIL basic_vector got=%h exp=f4", bus.irq_vector); end
`endif
    cyc();
    new_op();
    #1;
    checks++; if (bus.irq_ack !== 4'b0) begin errors++; $display("FAIL basic_ack_pulse got=%b exp=0000", bus.irq_ack); end
    checks++; if (opcode_out !== 8'hEF) begin errors++; $display("FAIL basic_inject_hold got=%h exp=ef", opcode_out); end
    boundary();
    checks++; if (bus.irq_active !== 1'b1) begin errors++; $display("FAIL basic_service got=%b exp=1", bus.irq_active); end
    checks++; if (opcode_out !== opcode_in) begin errors++; $display("FAIL basic_service_op got=%h exp=%h", opcode_out, opcode_in); end
    bus.irq_req = '0;
    do_reti();
    checks++; if (bus.irq_active !== 1'b0) begin errors++; $display("FAIL basic_reti got=%b exp=0", bus.irq_active); end
  endtask

  task automatic test_priority();
    do_reset();
    to_pending(4'b1010, 4'hF);
    boundary();
    checks++; if (bus.irq_ack !== 4'b0010) begin errors++; $display("FAIL prio_ack got=%b exp=0010", bus.irq_ack); end
    boundary();
    bus.irq_req = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      boundary();
      checks++; if (bus.irq_ack !== 4'b0 || bus.irq_active !== 1'b1)
        begin errors++; $display("FAIL prio_no_nest ack=%b active=%b exp ack=0000 active=1", bus.irq_ack, bus.irq_active); end
    end
    do_reti();
    cyc();
    boundary();
    checks++; if (bus.irq_ack !== 4'b0001) begin errors++; $display("FAIL prio_after_reti got=%b exp=0001", bus.irq_ack); end
    // a mask write after latching must not move the winner
    do_reset();
    to_pending(4'b0110, 4'hF);
    set_mask(4'b0100);
    boundary();
    checks++; if (bus.irq_ack !== 4'b0010) begin errors++; $display("FAIL prio_mask_latched got=%b exp=0010", bus.irq_ack); end
  endtask

  task automatic test_prefix();
    do_reset();
    to_pending(4'b0001, 4'hF);
    step_resetn = 1'b0;
    step_extn   = 1'b0;
    cyc();
    checks++; if (bus.irq_ack !== 4'b0) begin errors++; $display("FAIL prefix_defer_ack got=%b exp=0000", bus.irq_ack); end
    checks++; if (opcode_out !== opcode_in) begin errors++; $display("FAIL prefix_defer_op got=%h exp=%h", opcode_out, opcode_in); end
    step_extn = 1'b1;
    cyc();
    step_resetn = 1'b1;
    checks++; if (bus.irq_ack !== 4'b0001) begin errors++; $display("FAIL prefix_inject_ack got=%b exp=0001", bus.irq_ack); end
    checks++; if (opcode_out !== 8'hEF) begin errors++; $display("FAIL prefix_inject_op got=%h exp=ef", opcode_out); end
  endtask

  task automatic test_withdraw();
    do_reset();
    to_pending(4'b1000, 4'hF);
    bus.irq_req = '0;
    cyc();
    boundary();
    checks++; if (bus.irq_ack !== 4'b0) begin errors++; $display("FAIL withdraw_ack got=%b exp=0000", bus.irq_ack); end
    // ie still set: the request comes back and is taken without ie_set
    bus.irq_req = 4'b1000;
    cyc();
    boundary();
    checks++; if (bus.irq_ack !== 4'b1000) begin errors++; $display("FAIL withdraw_ie_kept got=%b exp=1000", bus.irq_ack); end
  endtask

  task automatic test_reset_mid_inject();
    do_reset();
    to_pending(4'b0100, 4'hF);
    boundary();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    checks++; if (opcode_out !== opcode_in) begin errors++; $display("FAIL rst_inject_op got=%h exp=%h", opcode_out, opcode_in); end
    checks++; if (bus.irq_ack !== 4'b0 || bus.irq_active !== 1'b0)
      begin errors++; $display("FAIL rst_inject_outs ack=%b active=%b exp ack=0000 active=0", bus.irq_ack, bus.irq_active); end
    bus.irq_req = 4'hF;
    boundary();
    boundary();
    checks++; if (bus.irq_ack !== 4'b0) begin errors++; $display("FAIL rst_inject_ignored got=%b exp=0000", bus.irq_ack); end
    set_ie();
    cyc();
    boundary();
    checks++; if (bus.irq_ack !== 4'b0) begin errors++; $display("FAIL rst_inject_mask0 got=%b exp=0000", bus.irq_ack); end
    set_mask(4'hF);
    cyc();
    boundary();
    checks++; if (bus.irq_ack !== 4'b0001) begin errors++; $display("FAIL rst_inject_rearm got=%b exp=0001", bus.irq_ack); end
  endtask

  task automatic test_return();
    do_reset();
    to_pending(4'b0100, 4'hF);
    boundary();
    boundary();
    do_reti();
    checks++; if (bus.irq_active !== 1'b0) begin errors++; $display("FAIL return_active got=%b exp=0", bus.irq_active); end
    step_resetn = 1'b0;
    cyc();
    checks++; if (bus.irq_ack !== 4'b0) begin errors++; $display("FAIL return_latency got=%b exp=0000", bus.irq_ack); end
    cyc();
    step_resetn = 1'b1;
    checks++; if (bus.irq_ack !== 4'b0100) begin errors++; $display("FAIL return_reenter got=%b exp=0100", bus.irq_ack); end
    do_reti();
    checks++; if (opcode_out !== 8'hEF) begin errors++; $display("FAIL return_reti_ignored got=%h exp=ef", opcode_out); end
    boundary();
    checks++; if (bus.irq_active !== 1'b1) begin errors++; $display("FAIL return_service got=%b exp=1", bus.irq_active); end
  endtask

  task automatic test_ie_control();
    do_reset();
    bus.irq_req = 4'b0010;
    set_mask(4'hF);
    bus.ie_set = 1'b1;
    bus.ie_clr = 1'b1;
    cyc();
    bus.ie_set = 1'b0;
    bus.ie_clr = 1'b0;
    boundary();
    boundary();
    checks++; if (bus.irq_ack !== 4'b0) begin errors++; $display("FAIL ie_clr_wins got=%b exp=0000", bus.irq_ack); end
    set_ie();
    cyc();
    boundary();
    checks++; if (bus.irq_ack !== 4'b0010) begin errors++; $display("FAIL ie_set_take got=%b exp=0010", bus.irq_ack); end
    boundary();
    set_ie();
    boundary();
    boundary();
    checks++; if (bus.irq_ack !== 4'b0 || bus.irq_active !== 1'b1)
      begin errors++; $display("FAIL ie_set_service ack=%b active=%b exp ack=0000 active=1", bus.irq_ack, bus.irq_active); end
  endtask

  // random masks/requests; reference winner is the lowest set bit of
  // (req & mask) at the time of latching, unaffected by later request changes
  task automatic test_random_prio();
    logic [3:0] m, r, p, exp;
    int         w;
    for (int it = 0; it < 24; it++) begin
      do_reset();
      m = 4'($urandom_range(1, 15));
      do r = 4'($urandom_range(1, 15)); while ((r & m) == 4'b0);
      p   = r & m;
      exp = p & (~p + 4'd1);
      w   = $clog2(exp);
      to_pending(r, m);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        do r = 4'($urandom_range(1, 15)); while ((r & m) == 4'b0);
        bus.irq_req = r;
        if ($urandom_range(0, 1) == 1) begin
          step_resetn = 1'b0;
          step_extn   = 1'b0;
        end
        cyc();
        step_resetn = 1'b1;
        step_extn   = 1'b1;
        checks++; if (bus.irq_ack !== 4'b0 || opcode_out !== opcode_in)
          begin errors++; $display("FAIL rand_wait it=%0d ack=%b op=%h exp ack=0000 op=%h", it, bus.irq_ack, opcode_out, opcode_in); end
      end
      boundary();
      checks++; if (bus.irq_ack !== exp) begin errors++; $display("FAIL rand_ack it=%0d m=%b got=%b exp=%b", it, m, bus.irq_ack, exp); end
`ifdef IRQ_VECTOR_EN
      checks++; if (bus.irq_vector !== 8'(8'hF0 + 2 * w))
        begin errors++; $display("FAIL rand_vector it=%0d got=%h exp=%h", it, bus.irq_vector, 8'(8'hF0 + 2 * w)); end
`endif
      cyc();
      checks++; if (bus.irq_ack !== 4'b0 || opcode_out !== 8'hEF)
        begin errors++; $display("FAIL rand_post it=%0d w=%0d ack=%b op=%h exp ack=0000 op=ef", it, w, bus.irq_ack, opcode_out); end
    end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    opcode_in = 8'h00;
    test_reset();
    test_basic();
    test_priority();
    test_prefix();
    test_withdraw();
    test_reset_mid_inject();
    test_return();
    test_ie_control();
    test_random_prio();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
